// File: rtl/wram_banked.sv
// Banked work-RAM on the 16-bit CPU bus: fixed lower half, switchable upper half,
// optional echo mirror, memory-mapped bank register and a registered read path.
module wram_banked #(
  parameter logic [15:0] BASE_ADDR     = 16'hC000,
  parameter int unsigned WIN_BITS      = 13,
  parameter int unsigned NUM_BANKS     = 8,
  parameter logic [15:0] BANK_REG_ADDR = 16'hFF70,
  parameter bit          ECHO_EN       = 1'b1,
  parameter logic [15:0] ECHO_BASE     = 16'hE000,
  parameter logic [15:0] ECHO_LAST     = 16'hFDFF,
  localparam int unsigned BW           = $clog2(NUM_BANKS)
) (
  input  logic          clka,
  input  logic          rsta,
  input  logic          ena,
  input  logic          wea,
  input  logic [15:0]   addra,
  input  logic [7:0]    dina,
  output logic [7:0]    douta,
  output logic          douta_oe,
  output logic          hit,
  output logic [BW-1:0] bank_o
);

  localparam int unsigned OW       = WIN_BITS - 1;
  localparam int unsigned AW       = BW + OW;
  localparam int unsigned DEPTH    = NUM_BANKS << OW;
  localparam logic [15:0] WIN_MASK = 16'((32'd1 << WIN_BITS) - 32'd1);

  logic [7:0]    mem [DEPTH];
  logic [BW-1:0] bank_raw;
  logic [15:0]   echo_addr;
  logic          in_win;
  logic          in_echo;
  logic          in_breg;
  logic          ram_sel;
  logic [OW-1:0] off;
  logic          hb;
  logic [AW-1:0] paddr;
  logic          wr_ram;
  logic          wr_breg;
  logic          rd_acc;

  // Echo accesses are rebased onto the window first, then decoded exactly like
  // a direct window access; a direct window hit takes precedence on overlap.
  always_comb begin
    echo_addr = addra - ECHO_BASE + BASE_ADDR;
    in_breg   = (addra == BANK_REG_ADDR);
    in_win    = ((addra & ~WIN_MASK) == BASE_ADDR);
    in_echo   = ECHO_EN && (addra >= ECHO_BASE) && (addra <= ECHO_LAST)
                && ((echo_addr & ~WIN_MASK) == BASE_ADDR);
    ram_sel   = !in_breg && (in_win || in_echo);
    if (in_win) begin
      off = addra[OW-1:0];
      hb  = addra[OW];
    end else begin
      off = echo_addr[OW-1:0];
      hb  = echo_addr[OW];
    end
  end

  always_comb begin
    bank_o = (bank_raw == '0) ? BW'(1) : bank_raw;
    paddr  = {(hb ? bank_o : BW'(0)), off};
  end

  always_comb begin
    hit     = ena && (in_breg || in_win || in_echo);
    wr_ram  = ena && wea && ram_sel;
    wr_breg = ena && wea && in_breg;
    rd_acc  = ena && !wea && hit;
  end

  // RAM contents survive reset, so the array has no reset branch.
  always_ff @(posedge clka) begin
    if (wr_ram) mem[paddr] <= dina;
  end

  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      bank_raw <= BW'(1);
    end else if (wr_breg) begin
      bank_raw <= dina[BW-1:0];
    end
  end

  // Register readback returns the raw value, not the bank-0 remap.
  always_ff @(posedge clka or posedge rsta) begin
    if (rsta) begin
      douta    <= '0;
      douta_oe <= 1'b0;
    end else begin
      douta_oe <= rd_acc;
      if (rd_acc) douta <= in_breg ? {{(8 - BW){1'b1}}, bank_raw} : mem[paddr];
    end
  end

endmodule

// File: tb/tb_wram_banked.sv
// Scoreboard bench for wram_banked: expected read data is queued at read issue
// and popped when the registered read data is sampled one cycle later.
module tb_wram_banked;

  logic        clka = 1'b0;
  logic        rsta;
  logic        ena;
  logic        wea;
  logic [15:0] addra;
  logic [7:0]  dina;
  logic [7:0]  douta;
  logic        douta_oe;
  logic        hit;
  logic [2:0]  bank_o;

  int passed = 0;
  int total  = 0;
  logic [7:0] sb [$];
  logic [7:0] e;

  wram_banked #(
    .BASE_ADDR    (16'hC000),
    .WIN_BITS     (13),
    .NUM_BANKS    (8),
    .BANK_REG_ADDR(16'hFF70),
    .ECHO_EN      (1'b1),
    .ECHO_BASE    (16'hE000),
    .ECHO_LAST    (16'hFDFF)
  ) dut (
    .clka    (clka),
    .rsta    (rsta),
    .ena     (ena),
    .wea     (wea),
    .addra   (addra),
    .dina    (dina),
    .douta   (douta),
    .douta_oe(douta_oe),
    .hit     (hit),
    .bank_o  (bank_o)
  );

  always #5 clka = ~clka;

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    ena = 1'b1; wea = 1'b1; addra = a; dina = d;
    @(posedge clka); #1;
    ena = 1'b0; wea = 1'b0;
  endtask

  task automatic rd(input logic [15:0] a, input logic [7:0] exp_v);
    ena = 1'b1; wea = 1'b0; addra = a;
    sb.push_back(exp_v);
    @(posedge clka); #1;
    ena = 1'b0;
  endtask

  task automatic idle();
    ena = 1'b0; wea = 1'b0;
    @(posedge clka); #1;
  endtask

  task automatic test_reset();
    rsta = 1'b1; ena = 1'b0; wea = 1'b0; addra = '0; dina = '0;
    repeat (2) @(posedge clka);
    #1 rsta = 1'b0;
    total++;
    if (douta === 8'h00 && douta_oe === 1'b0 && bank_o === 3'd1) passed++;
    else $display("FAIL reset_state: douta=%h oe=%b bank=%0d, expected 00 0 1", douta, douta_oe, bank_o);

    wr(16'hFF70, 8'h05);
    total++;
    if (bank_o === 3'd5) passed++;
    else $display("FAIL bank_load5: bank_o=%0d, expected 5", bank_o);
    wr(16'hC000, 8'hAA);
    wr(16'hFF70, 8'h01);
    wr(16'hD000, 8'h3C);
    wr(16'hFF70, 8'h05);
    wr(16'hD000, 8'h99);
    rd(16'hC000, 8'hAA);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL pre_reset_rd: douta=%h oe=%b, expected %h oe=1", douta, douta_oe, e);

    // read of C000 issued in the same cycle that reset asserts: discarded
    ena = 1'b1; wea = 1'b0; addra = 16'hC000;
    #2 rsta = 1'b1;
    @(posedge clka); #1;
    ena = 1'b0;
    total++;
    if (douta_oe === 1'b0 && douta === 8'h00 && bank_o === 3'd1) passed++;
    else $display("FAIL reset_mid_read: douta=%h oe=%b bank=%0d, expected 00 0 1", douta, douta_oe, bank_o);
    rsta = 1'b0;
    idle();
  endtask

  task automatic test_fixed_bank();
    rd(16'hD000, 8'h3C);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL ram_kept_bank1: douta=%h oe=%b, expected %h oe=1", douta, douta_oe, e);
    wr(16'hC123, 8'h5A);
    total++;
    if (douta_oe === 1'b0) passed++;
    else $display("FAIL write_no_oe: oe=%b, expected 0", douta_oe);
    rd(16'hC123, 8'h5A);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL fixed_c123: douta=%h oe=%b, expected %h oe=1", douta, douta_oe, e);
    idle();
    total++;
    if (douta_oe === 1'b0 && douta === 8'h5A) passed++;
    else $display("FAIL oe_one_cycle: douta=%h oe=%b, expected 5a oe=0", douta, douta_oe);
  endtask

  task automatic test_banking();
    wr(16'hFF70, 8'h03);
    wr(16'hD010, 8'hA1);
    wr(16'hFF70, 8'h05);
    wr(16'hD010, 8'hB2);
    wr(16'hFF70, 8'h03);
    rd(16'hD010, 8'hA1);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bank3_d010: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    wr(16'hFF70, 8'h05);
    rd(16'hD010, 8'hB2);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bank5_d010: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    wr(16'hFF70, 8'h00);
    total++;
    if (bank_o === 3'd1) passed++;
    else $display("FAIL bank0_remap: bank_o=%0d, expected 1", bank_o);
    ena = 1'b1; wea = 1'b0; addra = 16'hFF70;
    #1;
    total++;
    if (hit === 1'b1) passed++;
    else $display("FAIL hit_breg: hit=%b, expected 1", hit);
    sb.push_back(8'hF8);
    @(posedge clka); #1;
    ena = 1'b0;
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL breg_readback: douta=%h oe=%b, expected %h", douta, douta_oe, e);
  endtask

  task automatic test_echo();
    wr(16'hC456, 8'h77);
    ena = 1'b1; wea = 1'b0; addra = 16'hE456;
    #1;
    total++;
    if (hit === 1'b1) passed++;
    else $display("FAIL hit_echo: hit=%b, expected 1", hit);
    sb.push_back(8'h77);
    @(posedge clka); #1;
    ena = 1'b0;
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL echo_e456: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    wr(16'hFDFF, 8'h11);
    rd(16'hDDFF, 8'h11);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL echo_fdff: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    ena = 1'b1; wea = 1'b0; addra = 16'hFE00;
    #1;
    total++;
    if (hit === 1'b0) passed++;
    else $display("FAIL hit_fe00: hit=%b, expected 0", hit);
    @(posedge clka); #1;
    ena = 1'b0;
    total++;
    if (douta_oe === 1'b0) passed++;
    else $display("FAIL fe00_no_oe: oe=%b, expected 0", douta_oe);
  endtask

  task automatic test_back_to_back();
    logic [15:0] addrs [4];
    logic [7:0]  vals  [4];
    addrs = '{16'hC000, 16'hCFFF, 16'hD000, 16'hDFFF};
    vals  = '{8'hE1, 8'hE2, 8'hE3, 8'hE4};
    wr(16'hFF70, 8'h02);
    for (int i = 0; i < 4; i++) begin
      wr(addrs[i], vals[i]);
      rd(addrs[i], vals[i]);
      e = sb.pop_front(); total++;
      if (douta_oe === 1'b1 && douta === e) passed++;
      else $display("FAIL b2b_%0d: addr=%h douta=%h oe=%b, expected %h", i, addrs[i], douta, douta_oe, e);
    end
    ena = 1'b1; wea = 1'b1; addra = 16'hBFFF; dina = 8'h5F;
    #1;
    total++;
    if (hit === 1'b0) passed++;
    else $display("FAIL hit_bfff: hit=%b, expected 0", hit);
    @(posedge clka); #1;
    ena = 1'b0; wea = 1'b0;
    rd(16'hDFFF, 8'hE4);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bfff_no_write: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    rd(16'hCFFF, 8'hE2);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bfff_no_alias: douta=%h oe=%b, expected %h", douta, douta_oe, e);
  endtask

  task automatic test_bank_ff();
    wr(16'hFF70, 8'hFF);
    total++;
    if (bank_o === 3'd7) passed++;
    else $display("FAIL bank_ff: bank_o=%0d, expected 7", bank_o);
    wr(16'hD000, 8'h7E);
    rd(16'hFF70, 8'hFF);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL breg_ff_readback: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    wr(16'hFF70, 8'h01);
    rd(16'hD000, 8'h3C);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bank1_untouched: douta=%h oe=%b, expected %h", douta, douta_oe, e);
    wr(16'hFF70, 8'h07);
    rd(16'hD000, 8'h7E);
    e = sb.pop_front(); total++;
    if (douta_oe === 1'b1 && douta === e) passed++;
    else $display("FAIL bank7_d000: douta=%h oe=%b, expected %h", douta, douta_oe, e);
  endtask

  initial begin
    test_reset();
    test_fixed_bank();
    test_banking();
    test_echo();
    test_back_to_back();
    test_bank_ff();
    total++;
    if (sb.size() == 0) passed++;
    else $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
